// File: rtl/dec10to8_pkg.sv
// Shared constants, disparity classes and sub-block helpers for the 10b/8b decoder.
package dec10to8_pkg;

    localparam int CW_W   = 10;
    localparam int SB6_W  = 6;
    localparam int SB4_W  = 4;
    localparam int BYTE_W = 8;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    localparam logic [CW_W-1:0]   K28_5_RDN  = 10'h0FA;
    localparam logic [CW_W-1:0]   K28_5_RDP  = 10'h305;
    localparam logic [BYTE_W-1:0] K28_5_BYTE = 8'hBC;

    typedef enum logic [1:0] {
        DISP_NEUTRAL = 2'd0,
        DISP_POS     = 2'd1,
        DISP_NEG     = 2'd2,
        DISP_BAD     = 2'd3
    } disp_class_e;

    function automatic disp_class_e class6(input logic [SB6_W-1:0] s);
        disp_class_e c;
        case ($countones(s))
            3:       c = DISP_NEUTRAL;
            4:       c = DISP_POS;
            2:       c = DISP_NEG;
            default: c = DISP_BAD;
        endcase
        return c;
    endfunction

    function automatic disp_class_e class4(input logic [SB4_W-1:0] s);
        disp_class_e c;
        case ($countones(s))
            2:       c = DISP_NEUTRAL;
            3:       c = DISP_POS;
            1:       c = DISP_NEG;
            default: c = DISP_BAD;
        endcase
        return c;
    endfunction

    // Running disparity after a sub-block: nonzero blocks set RD to their own sign.
    function automatic logic rd_after(input disp_class_e c, input logic rd);
        logic r;
        case (c)
            DISP_POS: r = RD_POS;
            DISP_NEG: r = RD_NEG;
            default:  r = rd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dec4to3.sv
// Combinational 4b/3b sub-block decoder: fghj plus running disparity to HGF and checks.
module dec4to3
    import dec10to8_pkg::*;
(
    input  logic [SB4_W-1:0] fghj,
    input  logic             rd,
    output logic [2:0]       hgf,
    output disp_class_e      disp,
    output logic             code_err,
    output logic             disp_err
);

    always_comb begin
        hgf      = 3'd0;
        code_err = 1'b0;
        // Alternate codes 0111/1000 are deliberately absent and fall to the error arm.
        case (fghj)
            4'b1011, 4'b0100: hgf = 3'd0;
            4'b1001:          hgf = 3'd1;
            4'b0101:          hgf = 3'd2;
            4'b1100, 4'b0011: hgf = 3'd3;
            4'b1101, 4'b0010: hgf = 3'd4;
            4'b1010:          hgf = 3'd5;
            4'b0110:          hgf = 3'd6;
            4'b1110, 4'b0001: hgf = 3'd7;
            default:          code_err = 1'b1;
        endcase

        disp     = class4(fghj);
        disp_err = !code_err &&
                   ((disp == DISP_POS && rd == RD_POS) ||
                    (disp == DISP_NEG && rd == RD_NEG) ||
                    (fghj == 4'b1100 && rd == RD_POS)  ||
                    (fghj == 4'b0011 && rd == RD_NEG));
    end

endmodule

// File: rtl/dec10to8.sv
// Two-stage 8b/10b symbol decoder with running-disparity tracking and K28.5 detection.
module dec10to8
    import dec10to8_pkg::*;
#(
    parameter logic RD_INIT = RD_NEG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CW_W-1:0]   codeword,
    output logic              out_valid,
    output logic [BYTE_W-1:0] dataout,
    output logic              is_k,
    output logic              code_err,
    output logic              disp_err,
    output logic              rd_out
);

    // in_valid qualifies codeword; there is no ready, so every cycle with
    // in_valid high is one accepted word, emitted exactly two cycles later.
    logic              s1_valid;
    logic [CW_W-1:0]   s1_code;
    logic              rd;

    logic [SB6_W-1:0]  sb6;
    logic [SB4_W-1:0]  sb4;
    logic [4:0]        edcba;
    logic              err6;
    disp_class_e       c6;
    logic              bad6;
    logic              rd_mid;
    logic              k_prefix;
    logic              k_match;

    logic [2:0]        hgf;
    disp_class_e       c4;
    logic              err4;
    logic              bad4;

    logic              rd_next;
    logic              word_err;
    logic              word_disp_err;

    assign sb6 = s1_code[CW_W-1:SB4_W];
    assign sb4 = s1_code[SB4_W-1:0];

    always_comb begin
        edcba = 5'd0;
        err6  = 1'b0;
        case (sb6)
            6'b100111, 6'b011000: edcba = 5'd0;
            6'b011101, 6'b100010: edcba = 5'd1;
            6'b101101, 6'b010010: edcba = 5'd2;
            6'b110001:            edcba = 5'd3;
            6'b110101, 6'b001010: edcba = 5'd4;
            6'b101001:            edcba = 5'd5;
            6'b011001:            edcba = 5'd6;
            6'b111000, 6'b000111: edcba = 5'd7;
            6'b111001, 6'b000110: edcba = 5'd8;
            6'b100101:            edcba = 5'd9;
            6'b010101:            edcba = 5'd10;
            6'b110100:            edcba = 5'd11;
            6'b001101:            edcba = 5'd12;
            6'b101100:            edcba = 5'd13;
            6'b011100:            edcba = 5'd14;
            6'b010111, 6'b101000: edcba = 5'd15;
            6'b011011, 6'b100100: edcba = 5'd16;
            6'b100011:            edcba = 5'd17;
            6'b010011:            edcba = 5'd18;
            6'b110010:            edcba = 5'd19;
            6'b001011:            edcba = 5'd20;
            6'b101010:            edcba = 5'd21;
            6'b011010:            edcba = 5'd22;
            6'b111010, 6'b000101: edcba = 5'd23;
            6'b110011, 6'b001100: edcba = 5'd24;
            6'b100110:            edcba = 5'd25;
            6'b010110:            edcba = 5'd26;
            6'b110110, 6'b001001: edcba = 5'd27;
            6'b001110:            edcba = 5'd28;
            6'b101110, 6'b010001: edcba = 5'd29;
            6'b011110, 6'b100001: edcba = 5'd30;
            6'b101011, 6'b010100: edcba = 5'd31;
            6'b001111, 6'b110000: edcba = 5'd28;
            default:              err6  = 1'b1;
        endcase

        c6   = class6(sb6);
        bad6 = (c6 == DISP_POS && rd == RD_POS) ||
               (c6 == DISP_NEG && rd == RD_NEG) ||
               (sb6 == 6'b111000 && rd == RD_POS) ||
               (sb6 == 6'b000111 && rd == RD_NEG);
        rd_mid = rd_after(c6, rd);

        // The K28 6b prefix is only legal as part of a complete K28.5 word.
        k_prefix = (sb6 == 6'b001111) || (sb6 == 6'b110000);
        k_match  = (s1_code == K28_5_RDN) || (s1_code == K28_5_RDP);
    end

    dec4to3 u_dec4to3 (
        .fghj     (sb4),
        .rd       (rd_mid),
        .hgf      (hgf),
        .disp     (c4),
        .code_err (err4),
        .disp_err (bad4)
    );

    always_comb begin
        rd_next       = rd_after(c4, rd_mid);
        word_err      = err6 || err4 || (k_prefix && !k_match);
        word_disp_err = bad6 || bad4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_code   <= '0;
            out_valid <= 1'b0;
            dataout   <= '0;
            is_k      <= 1'b0;
            code_err  <= 1'b0;
            disp_err  <= 1'b0;
            rd        <= RD_INIT;
        end else begin
            s1_valid  <= in_valid;
            s1_code   <= codeword;
            out_valid <= s1_valid;
            // Idle cycles hold the previous word's outputs and RD.
            if (s1_valid) begin
                if (word_err) begin
                    dataout  <= '0;
                    is_k     <= 1'b0;
                    code_err <= 1'b1;
                    disp_err <= 1'b0;
                end else begin
                    dataout  <= k_match ? K28_5_BYTE : {hgf, edcba};
                    is_k     <= k_match;
                    code_err <= 1'b0;
                    disp_err <= word_disp_err;
                    rd       <= rd_next;
                end
            end
        end
    end

    assign rd_out = rd;

endmodule

// File: tb/tb_dec10to8.sv
// Directed bench for dec10to8: status packed as {out_valid, dataout, is_k, code_err, disp_err, rd_out}.
module tb_dec10to8;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [9:0] codeword;
    logic       out_valid;
    logic [7:0] dataout;
    logic       is_k;
    logic       code_err;
    logic       disp_err;
    logic       rd_out;

    int n_checks = 0;
    int n_errors = 0;

    dec10to8 #(.RD_INIT(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .codeword  (codeword),
        .out_valid (out_valid),
        .dataout   (dataout),
        .is_k      (is_k),
        .code_err  (code_err),
        .disp_err  (disp_err),
        .rd_out    (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] status();
        return {out_valid, dataout, is_k, code_err, disp_err, rd_out};
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        codeword = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [12:0] exp_v;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        codeword = '0;
        repeat (2) @(negedge clk);
        exp_v = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (status() !== exp_v) begin
            n_errors++;
            $display("FAIL reset_held: got %h expected %h", status(), exp_v);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (status() !== exp_v) begin
            n_errors++;
            $display("FAIL reset_released: got %h expected %h", status(), exp_v);
        end
    endtask

    task automatic test_data();
        logic [12:0] exp_v;
        do_reset();
        in_valid = 1'b1;
        codeword = 10'h274;
        @(negedge clk);
        in_valid = 1'b0;
        codeword = '0;
        exp_v = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (status() !== exp_v) begin
            n_errors++;
            $display("FAIL data_latency1: got %h expected %h", status(), exp_v);
        end
        @(negedge clk);
        exp_v = {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (status() !== exp_v) begin
            n_errors++;
            $display("FAIL data_d0: got %h expected %h", status(), exp_v);
        end
    endtask

    task automatic test_k28();
        logic [9:0]  cw [2] = '{10'h0FA, 10'h305};
        logic [12:0] ex [2] = '{{1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1},
                                {1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0}};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i >= 2) begin
                n_checks++;
                if (status() !== ex[i-2]) begin
                    n_errors++;
                    $display("FAIL k28[%0d]: got %h expected %h", i - 2, status(), ex[i-2]);
                end
            end
            if (i < 2) begin
                in_valid = 1'b1;
                codeword = cw[i];
            end else begin
                in_valid = 1'b0;
                codeword = '0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_k28_wrong_rd();
        logic [12:0] exp_v;
        do_reset();
        in_valid = 1'b1;
        codeword = 10'h305;
        @(negedge clk);
        in_valid = 1'b0;
        codeword = '0;
        @(negedge clk);
        exp_v = {1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if (status() !== exp_v) begin
            n_errors++;
            $display("FAIL k28_wrong_rd: got %h expected %h", status(), exp_v);
        end
    endtask

    task automatic test_disparity();
        logic [9:0]  cw [5] = '{10'h0FA, 10'h38A, 10'h2AD, 10'h18B, 10'h2A0};
        logic [12:0] ex [5] = '{{1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1},
                                {1'b1, 8'hA7, 1'b0, 1'b0, 1'b1, 1'b1},
                                {1'b1, 8'h95, 1'b0, 1'b0, 1'b1, 1'b1},
                                {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1},
                                {1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1}};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i >= 2) begin
                n_checks++;
                if (status() !== ex[i-2]) begin
                    n_errors++;
                    $display("FAIL disparity[%0d]: got %h expected %h", i - 2, status(), ex[i-2]);
                end
            end
            if (i < 5) begin
                in_valid = 1'b1;
                codeword = cw[i];
            end else begin
                in_valid = 1'b0;
                codeword = '0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_code_err();
        logic [9:0]  cw [6] = '{10'h3FF, 10'h1D8, 10'h2A7, 10'h3CA, 10'h0F5, 10'h274};
        logic [12:0] ex [6] = '{{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
                                {1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
                                {1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
                                {1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
                                {1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
                                {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i >= 2) begin
                n_checks++;
                if (status() !== ex[i-2]) begin
                    n_errors++;
                    $display("FAIL code_err[%0d]: got %h expected %h", i - 2, status(), ex[i-2]);
                end
            end
            if (i < 6) begin
                in_valid = 1'b1;
                codeword = cw[i];
            end else begin
                in_valid = 1'b0;
                codeword = '0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_gaps();
        logic        vld [3] = '{1'b1, 1'b0, 1'b1};
        logic [12:0] ex  [3] = '{{1'b1, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0},
                                 {1'b0, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0},
                                 {1'b1, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0}};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) begin
                n_checks++;
                if (status() !== ex[i-2]) begin
                    n_errors++;
                    $display("FAIL gaps[%0d]: got %h expected %h", i - 2, status(), ex[i-2]);
                end
            end
            if (i < 3) begin
                in_valid = vld[i];
                codeword = vld[i] ? 10'h2AA : 10'h3FF;
            end else begin
                in_valid = 1'b0;
                codeword = '0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midstream();
        logic [12:0] exp_v;
        do_reset();
        in_valid = 1'b1;
        codeword = 10'h0FA;
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        codeword = '0;
        #1;
        exp_v = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (status() !== exp_v) begin
            n_errors++;
            $display("FAIL midreset_held: got %h expected %h", status(), exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (status() !== exp_v) begin
                n_errors++;
                $display("FAIL midreset_after[%0d]: got %h expected %h", i, status(), exp_v);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        codeword = '0;
        test_reset();
        test_data();
        test_k28();
        test_k28_wrong_rd();
        test_disparity();
        test_code_err();
        test_gaps();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dec10to8.md
DEC10TO8 -- requirements
Module: dec10to8

Interface
REQ-001 Parameter RD_INIT, default 0, running disparity loaded at reset (0 = negative, 1 = positive).
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port in_valid  input  1  codeword qualifier; one codeword per cycle, no backpressure.
REQ-005 Port codeword  input  10  received symbol: [9:4] = abcdei (a at bit 9); [3:0] = fghj (f at bit 3).
REQ-006 Port out_valid  output  1  dataout and flags valid this cycle.
REQ-007 Port dataout  output  8  decoded byte: [7:5] = HGF, [4:0] = EDCBA.
REQ-008 Port is_k  output  1  K28.5 comma received; dataout = 8'hBC.
REQ-009 Port code_err  output  1  codeword not in the supported code table.
REQ-010 Port disp_err  output  1  sub-block disparity illegal for the current running disparity.
REQ-011 Port rd_out  output  1  running disparity after the last valid codeword (1 = positive).

Function
REQ-012 The decoder SHALL use a 2-stage pipeline: stage 1 registers codeword and in_valid; stage 2 decodes, updates RD and registers all outputs.
REQ-013 Latency SHALL be exactly 2 cycles: out_valid equals in_valid delayed by 2 cycles, including across gaps.
REQ-014 RD SHALL update only on valid codewords; invalid cycles leave RD and the data outputs unchanged.
REQ-015 6b sub-block class, by count of ones: 3 = neutral, 4 = +2, 2 = -2, any other count = code_err.
REQ-016 4b sub-block class, by count of ones: 2 = neutral, 3 = +2, 1 = -2, any other count = code_err.
REQ-017 The 6b sub-block SHALL be checked against the current RD; the 4b sub-block SHALL be checked against the RD after the 6b sub-block.
REQ-018 disp_err SHALL be set when either of the following holds:
- a +2 sub-block arrives at positive RD;
- a -2 sub-block arrives at negative RD.
REQ-019 disp_err SHALL also be set when either of the following holds:
- 111000 or 1100 arrives at positive RD;
- 000111 or 0011 arrives at negative RD.
REQ-020 A nonzero-disparity sub-block SHALL flip RD.
- On disp_err, RD follows the received disparity (resynchronises).
- dataout is still decoded.
REQ-021 The 6b/5b table SHALL be the standard 8b/10b D-code set.
REQ-022 The 4b/3b table SHALL be the exact inverse of the team's 3b/4b encoder.
- x.0: 1011/0100; x.1: 1001; x.2: 0101; x.3: 1100/0011.
- x.4: 1101/0010; x.5: 1010; x.6: 0110; x.7: 1110/0001.
REQ-023 The alternate 4b codes 0111 and 1000 SHALL flag code_err.
REQ-024 The only supported control code SHALL be K28.5: 0011111010 at RD-, 1100000101 at RD+. Any other 6b 001111/110000 combination SHALL flag code_err.
REQ-025 On code_err: dataout = 8'h00, is_k = 0, disp_err = 0, RD unchanged.
REQ-026 If the reset deasserts mid-stream, the decoder SHALL restart from RD_INIT with an empty pipeline; a codeword in flight at reset SHALL be discarded.

Reset
REQ-027 While rst_n is low, all of the following SHALL hold:
- out_valid = 0, dataout = 8'h00, is_k = 0, code_err = 0, disp_err = 0;
- rd_out = RD_INIT;
- both pipeline valid bits = 0.

Structure
REQ-028 The shared package SHALL hold:
- codeword widths;
- RD encoding constants;
- K28_5_RDN = 10'h0FA, K28_5_RDP = 10'h305, K28_5_BYTE = 8'hBC.
REQ-029 One combinational sub-module dec4to3 SHALL map fghj plus RD to HGF, its disparity class and a code-error flag; all sequential logic stays in dec10to8.

Verification
REQ-030 Reset with RD_INIT = 0, then 10'h274 valid -> 2 cycles later: out_valid = 1, dataout = 8'h00, rd_out = 0, no errors.
REQ-031 10'h0FA at RD- then 10'h305 -> is_k = 1, dataout = 8'hBC both times; rd_out = 1 after the first, 0 after the second.
REQ-032 10'h305 at RD- -> disp_err = 1, is_k = 1, rd_out = 0.
REQ-033 10'h3FF at RD-, then 10'h1D8 (A7 code) at RD- -> code_err = 1, dataout = 8'h00 and rd_out = 0 for both.
REQ-034 10'h2AA with in_valid pattern 1,0,1 -> dataout = 8'hB5 with out_valid pattern 1,0,1 two cycles later; rd_out constant.
REQ-035 rst_n pulsed low while a codeword is in stage 1 -> no out_valid follows; rd_out = RD_INIT.
